// File: rtl/cdc_fifo_arb_pkg.sv
// Purpose : shared types and field layout for the cdc_fifo source-side arbiter and its destination demux.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
package cdc_fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Fields of one FIFO word, {idx, last, data} with idx in the MSBs.
   typedef enum logic [1:0] {
      FLD_DATA = 2'd0,
      FLD_LAST = 2'd1,
      FLD_IDX  = 2'd2
   } fifo_field_e;

   // LSB position of a field inside the FIFO word. The destination demux uses
   // the same function so both sides agree on the layout.
   function automatic int fifo_field_lsb(input int data_width, input fifo_field_e fld);
      case (fld)
         FLD_DATA: return 0;
         FLD_LAST: return data_width;
         default:  return data_width + 1;
      endcase
   endfunction

endpackage

// File: rtl/cdc_fifo_src_arbiter_rr_pick.sv
// Purpose : combinational round-robin first-one finder, searching upward from start_i with wraparound.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; result follows vec_i/start_i directly.
// Ports   : vec_i candidate bits, start_i search start (< NumReq), idx_o first set index, found_o any bit set.
module rr_pick #(
   parameter int NumReq   = 4,
   parameter int IdxWidth = $clog2(NumReq)
) (
   input  logic [NumReq-1:0]   vec_i,
   input  logic [IdxWidth-1:0] start_i,
   output logic [IdxWidth-1:0] idx_o,
   output logic                found_o
);

   int                  pos;
   logic [IdxWidth-1:0] pos_idx;

   // Walk the offsets from farthest to nearest so the nearest set bit to
   // start_i is the last one written. start_i < NumReq, so one subtraction
   // is enough for the wrap even when NumReq is not a power of two.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      pos     = 0;
      pos_idx = '0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         pos = int'(start_i) + k;
         if (pos >= NumReq) begin
            pos = pos - NumReq;
         end
         pos_idx = IdxWidth'(pos);
         if (vec_i[pos_idx]) begin
            idx_o   = pos_idx;
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdc_fifo_src_arbiter.sv
// Purpose : shares one cdc_fifo_gray source port between NumReq packet requesters, round-robin with packet lock.
// Latency : 1 cycle from a valid seen in IDLE to fifo_valid_o; 0 cycles per beat while the grant is held.
// Backpr. : fifo_ready_i=0 stalls the granted requester indefinitely; non-granted requesters always see ready=0.
// Ports   : clk_i/rst_i (sync, active-high), en_i gates new grants, req_* per-requester beat stream,
//           fifo_* to the FIFO source port ({idx,last,data}), busy_o/gnt_idx_o grant status, err_o sticky overlength.
module cdc_fifo_src_arbiter
   import cdc_fifo_arb_pkg::*;
#(
   parameter int NumReq    = 4,
   parameter int DataWidth = 32,
   parameter int MaxBeats  = 16,
   parameter int IdxWidth  = $clog2(NumReq),
   parameter int FifoWidth = IdxWidth + 1 + DataWidth
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          en_i,
   input  logic [NumReq-1:0]             req_valid_i,
   output logic [NumReq-1:0]             req_ready_o,
   input  logic [NumReq*DataWidth-1:0]   req_data_i,
   input  logic [NumReq-1:0]             req_last_i,
   output logic                          fifo_valid_o,
   input  logic                          fifo_ready_i,
   output logic [FifoWidth-1:0]          fifo_data_o,
   output logic                          busy_o,
   output logic [IdxWidth-1:0]           gnt_idx_o,
   output logic                          err_o
);

   localparam int CntWidth = $clog2(MaxBeats + 1);
   localparam int DataLsb  = fifo_field_lsb(DataWidth, FLD_DATA);
   localparam int LastLsb  = fifo_field_lsb(DataWidth, FLD_LAST);
   localparam int IdxLsb   = fifo_field_lsb(DataWidth, FLD_IDX);

   arb_state_e          state_q, state_d;
   logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
   logic [IdxWidth-1:0] gnt_q, gnt_d;
   logic [CntWidth-1:0] beat_cnt_q, beat_cnt_d;
   logic                err_q, err_d;

   logic [IdxWidth-1:0]  sel_idx;
   logic                 sel_found;
   logic [DataWidth-1:0] req_data_arr [NumReq];
   logic                 gnt_valid;
   logic                 gnt_last;
   logic                 handshake;

   for (genvar g = 0; g < NumReq; g++) begin : g_unpack
      assign req_data_arr[g] = req_data_i[g*DataWidth +: DataWidth];
   end

   rr_pick #(
      .NumReq   (NumReq),
      .IdxWidth (IdxWidth)
   ) u_rr_pick (
      .vec_i   (req_valid_i),
      .start_i (rr_ptr_q),
      .idx_o   (sel_idx),
      .found_o (sel_found)
   );

   assign gnt_valid = req_valid_i[gnt_q];
   assign gnt_last  = req_last_i[gnt_q];

   // Datapath outputs. fifo_valid_o is built only from state and the granted
   // requester's valid, never from fifo_ready_i.
   always_comb begin
      fifo_valid_o = 1'b0;
      req_ready_o  = '0;
      fifo_data_o  = '0;
      fifo_data_o[DataLsb +: DataWidth] = req_data_arr[gnt_q];
      fifo_data_o[LastLsb]              = gnt_last;
      fifo_data_o[IdxLsb +: IdxWidth]   = gnt_q;
      if (state_q == BUSY) begin
         fifo_valid_o       = gnt_valid;
         req_ready_o[gnt_q] = fifo_ready_i;
      end
   end

   assign handshake = fifo_valid_o & fifo_ready_i;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_d      = gnt_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (en_i && sel_found) begin
               gnt_d      = sel_idx;
               state_d    = BUSY;
               beat_cnt_d = '0;
            end
         end
         BUSY: begin
            if (handshake) begin
               // beat_cnt already at MaxBeats means this beat is number
               // MaxBeats+1: the packet is overlength. It is still forwarded.
               if (beat_cnt_q == CntWidth'(MaxBeats)) begin
                  err_d = 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
               if (gnt_last) begin
                  state_d    = IDLE;
                  beat_cnt_d = '0;
                  rr_ptr_d   = (gnt_q == IdxWidth'(NumReq - 1)) ? '0 : gnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         gnt_q      <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_q      <= gnt_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   assign busy_o    = (state_q == BUSY);
   assign gnt_idx_o = gnt_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
module tb_cdc_fifo_src_arbiter;

   localparam int NumReq   = 4;
   localparam int DW       = 32;
   localparam int MaxBeats = 16;
   localparam int IW       = 2;
   localparam int FW       = IW + 1 + DW;

   logic              clk;
   logic              rst_i;
   logic              en_i;
   logic [NumReq-1:0] req_valid_i;
   logic [NumReq-1:0] req_ready_o;
   logic [NumReq*DW-1:0] req_data_i;
   logic [NumReq-1:0] req_last_i;
   logic              fifo_valid_o;
   logic              fifo_ready_i;
   logic [FW-1:0]     fifo_data_o;
   logic              busy_o;
   logic [IW-1:0]     gnt_idx_o;
   logic              err_o;

   cdc_fifo_src_arbiter #(
      .NumReq    (NumReq),
      .DataWidth (DW),
      .MaxBeats  (MaxBeats)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .en_i         (en_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_data_i   (req_data_i),
      .req_last_i   (req_last_i),
      .fifo_valid_o (fifo_valid_o),
      .fifo_ready_i (fifo_ready_i),
      .fifo_data_o  (fifo_data_o),
      .busy_o       (busy_o),
      .gnt_idx_o    (gnt_idx_o),
      .err_o        (err_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   // Per-requester beat queues {last, data} and the expected FIFO word stream.
   logic [DW:0]   src_q [NumReq][$];
   logic [FW-1:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] beat_data(input int req, input int tag, input int beat);
      return DW'((tag << 16) | (req << 8) | beat);
   endfunction

   task automatic drive_lines();
      for (int i = 0; i < NumReq; i++) begin
         if (src_q[i].size() > 0) begin
            req_valid_i[i]            = 1'b1;
            req_last_i[i]             = src_q[i][0][DW];
            req_data_i[i*DW +: DW]    = src_q[i][0][DW-1:0];
         end else begin
            req_valid_i[i]            = 1'b0;
            req_last_i[i]             = 1'b0;
            req_data_i[i*DW +: DW]    = '0;
         end
      end
   endtask

   // Queue a packet on a requester and the matching beats on the expected stream.
   // Callers issue packets in the hand-derived grant order.
   task automatic push_pkt(input int req, input int nbeats, input int tag, input int n_exp);
      for (int b = 0; b < nbeats; b++) begin
         src_q[req].push_back({(b == nbeats - 1), beat_data(req, tag, b)});
      end
      for (int b = 0; b < n_exp; b++) begin
         exp_q.push_back({IW'(req), (b == nbeats - 1), beat_data(req, tag, b)});
      end
      drive_lines();
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || busy_o) && k < budget) begin
         step(1);
         k++;
      end
      chk(name, 64'((exp_q.size() == 0) && !busy_o), 64'd1);
   endtask

   // Requester model: a beat leaves its queue when valid&ready were both high at the edge.
   initial begin
      logic [NumReq-1:0] hs_req;
      forever begin
         @(negedge clk);
         hs_req = req_valid_i & req_ready_o;
         @(posedge clk);
         #1;
         for (int i = 0; i < NumReq; i++) begin
            if (hs_req[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         end
         drive_lines();
      end
   end

   // Monitor: every beat accepted by the FIFO is compared with the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (fifo_valid_o && fifo_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_beat", 64'(fifo_data_o), 64'h0);
            else                   chk("beat_data", 64'(fifo_data_o), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_i        = 1'b1;
      en_i         = 1'b1;
      fifo_ready_i = 1'b1;
      req_valid_i  = '0;
      req_last_i   = '0;
      req_data_i   = '0;
      step(2);
      chk("rst_busy",  64'(busy_o), 64'd0);
      chk("rst_valid", 64'(fifo_valid_o), 64'd0);
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_gnt",   64'(gnt_idx_o), 64'd0);
      chk("rst_err",   64'(err_o), 64'd0);
      rst_i = 1'b0;
      step(1);

      // Round robin with 1-beat packets: order 0,1,2,3,0 at 2 cycles each.
      push_pkt(0, 1, 1, 1);
      push_pkt(1, 1, 2, 1);
      push_pkt(2, 1, 3, 1);
      push_pkt(3, 1, 4, 1);
      push_pkt(0, 1, 5, 1);
      step(1);
      chk("rr_first_gnt", 64'(gnt_idx_o), 64'd0);
      step(8);
      chk("rr_pending", 64'(exp_q.size()), 64'd1);
      step(1);
      chk("rr_drained", 64'(exp_q.size()), 64'd0);
      chk("rr_idle", 64'(busy_o), 64'd0);

      // Packet lock: rr_ptr=1, requester 2 (3 beats) wins over 0, then 0.
      push_pkt(2, 3, 6, 3);
      push_pkt(0, 1, 7, 1);
      step(1);
      chk("lock_gnt", 64'(gnt_idx_o), 64'd2);
      chk("lock_busy", 64'(busy_o), 64'd1);
      step(2);
      chk("lock_held", 64'(gnt_idx_o), 64'd2);
      chk("lock_other_rdy", 64'(req_ready_o[0]), 64'd0);
      wait_drain("lock_drain", 20);

      // Backpressure mid-packet: requester 1, stall 5 cycles after beat 0.
      push_pkt(1, 4, 8, 4);
      step(2);
      fifo_ready_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step(1);
         chk("bp_valid", 64'(fifo_valid_o), 64'd1);
         chk("bp_data", 64'(fifo_data_o), 64'({2'd1, 1'b0, beat_data(1, 8, 1)}));
         chk("bp_ready", 64'(req_ready_o), 64'd0);
      end
      fifo_ready_i = 1'b1;
      wait_drain("bp_drain", 20);

      // Exactly MaxBeats is legal; MaxBeats+1 raises err one cycle after the last handshake.
      push_pkt(3, 16, 9, 16);
      wait_drain("max_drain", 40);
      chk("err_at_max", 64'(err_o), 64'd0);
      push_pkt(1, 17, 10, 17);
      step(17);
      chk("err_before", 64'(err_o), 64'd0);
      step(1);
      chk("err_after", 64'(err_o), 64'd1);
      wait_drain("over_drain", 10);
      step(3);
      chk("err_sticky", 64'(err_o), 64'd1);

      // Enable low blocks grants; once high, order from rr_ptr=2 is 2,3,0,1.
      en_i = 1'b0;
      push_pkt(2, 1, 11, 1);
      push_pkt(3, 1, 12, 1);
      push_pkt(0, 1, 13, 1);
      push_pkt(1, 1, 14, 1);
      step(3);
      chk("en_busy", 64'(busy_o), 64'd0);
      chk("en_valid", 64'(fifo_valid_o), 64'd0);
      chk("en_pending", 64'(exp_q.size()), 64'd4);
      en_i = 1'b1;
      wait_drain("en_drain", 30);

      // Enable dropped mid-packet: packet completes, then no new grant.
      push_pkt(2, 3, 15, 3);
      push_pkt(0, 1, 16, 1);
      step(1);
      en_i = 1'b0;
      step(5);
      chk("endrop_busy", 64'(busy_o), 64'd0);
      chk("endrop_pending", 64'(exp_q.size()), 64'd1);
      en_i = 1'b1;
      wait_drain("endrop_drain", 20);

      // Reset mid-packet: 3 beats reach the FIFO, then everything clears.
      chk("err_pre_rst", 64'(err_o), 64'd1);
      push_pkt(3, 5, 17, 3);
      step(3);
      rst_i = 1'b1;
      step(1);
      chk("mrst_busy",  64'(busy_o), 64'd0);
      chk("mrst_ready", 64'(req_ready_o), 64'd0);
      chk("mrst_valid", 64'(fifo_valid_o), 64'd0);
      chk("mrst_gnt",   64'(gnt_idx_o), 64'd0);
      chk("mrst_err",   64'(err_o), 64'd0);
      chk("mrst_partial", 64'(exp_q.size()), 64'd0);
      rst_i = 1'b0;
      src_q[3].delete();
      drive_lines();
      // rr_ptr back at 0: requester 0 must win over 1.
      push_pkt(0, 1, 18, 1);
      push_pkt(1, 1, 19, 1);
      wait_drain("mrst_drain", 20);

      step(2);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
